// File: rtl/pipe_stage.sv
// pipe_stage: parametrised pipeline register with a valid/ready handshake,
// a synchronous flush that leaves a BUBBLE payload behind, and a saturating
// stall counter.
// Build option: define PIPE_SKID_EN to add a skid entry, which makes
// in_ready_o a registered signal. When it is undefined the stage has a
// single entry and in_ready_o depends combinationally on out_ready_i.
module pipe_stage #(
  parameter int unsigned                DATA_W = 134,
  parameter logic [DATA_W-1:0]          BUBBLE = {32'h0000_0013, 102'b0},
  parameter int unsigned                CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  logic              main_v_q, main_v_d;
  logic [DATA_W-1:0] main_d_q, main_d_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              in_xfer;
  logic              out_xfer;

  assign out_xfer = main_v_q && out_ready_i;
  assign in_xfer  = in_valid_i && in_ready_o;

`ifdef PIPE_SKID_EN
  logic              skid_v_q, skid_v_d;
  logic [DATA_W-1:0] skid_d_q, skid_d_d;

  assign in_ready_o = !skid_v_q;

  // Next state of both entries. The skid entry only fills while main is
  // stalled, so it is always empty whenever main is empty; a full skid
  // blocks the input, so an output transfer never sees a competing input.
  always_comb begin
    main_v_d = main_v_q;
    main_d_d = main_d_q;
    skid_v_d = skid_v_q;
    skid_d_d = skid_d_q;
    if (flush_i) begin
      main_v_d = 1'b0;
      main_d_d = BUBBLE;
      skid_v_d = 1'b0;
      skid_d_d = '0;
    end else if (out_xfer) begin
      if (skid_v_q) begin
        main_v_d = 1'b1;
        main_d_d = skid_d_q;
        skid_v_d = 1'b0;
        skid_d_d = '0;
      end else if (in_xfer) begin
        main_v_d = 1'b1;
        main_d_d = in_data_i;
      end else begin
        main_v_d = 1'b0;
        main_d_d = BUBBLE;
      end
    end else if (in_xfer) begin
      if (!main_v_q) begin
        main_v_d = 1'b1;
        main_d_d = in_data_i;
      end else begin
        skid_v_d = 1'b1;
        skid_d_d = in_data_i;
      end
    end
  end

  // Skid entry register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_v_q <= 1'b0;
      skid_d_q <= '0;
    end else begin
      skid_v_q <= skid_v_d;
      skid_d_q <= skid_d_d;
    end
  end
`else
  assign in_ready_o = !main_v_q || out_ready_i;

  // Next state of the single entry: flush wins, then refill, then drain.
  always_comb begin
    main_v_d = main_v_q;
    main_d_d = main_d_q;
    if (flush_i) begin
      main_v_d = 1'b0;
      main_d_d = BUBBLE;
    end else if (in_xfer) begin
      main_v_d = 1'b1;
      main_d_d = in_data_i;
    end else if (out_xfer) begin
      main_v_d = 1'b0;
      main_d_d = BUBBLE;
    end
  end
`endif

  // Saturating count of edges on which a valid payload is held back.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_v_q && !out_ready_i && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Main entry and stall counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_v_q    <= 1'b0;
      main_d_q    <= BUBBLE;
      stall_cnt_q <= '0;
    end else begin
      main_v_q    <= main_v_d;
      main_d_q    <= main_d_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid_o = main_v_q;
  assign out_data_o  = main_d_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: doc/pipe_stage.md
# pipe_stage

Parametrised pipeline stage register with a valid/ready handshake, synchronous flush and a saturating stall counter. It replaces the fixed-width ID/EX style registers between CPU pipeline stages. Back-pressure propagates upstream without losing data, and flushes insert a bubble carrying a NOP encoding. An optional skid entry registers the upstream ready path.

## Interface
Parameters:
- DATA_W, 134: payload width. Default packs {inst[31:0], inst_addr[31:0], op1[31:0], op2[31:0], rd_addr[4:0], reg_wen}.
- BUBBLE, {32'h0000_0013, 102'b0}: payload presented whenever the stage holds no valid data. The default puts the NOP instruction in the top 32 bits and zero elsewhere.
- CNT_W, 16: stall counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- flush_i  input  1  synchronous kill of all held and incoming data.
- in_valid_i  input  1  upstream payload valid.
- in_ready_o  output  1  stage can accept a payload this cycle.
- in_data_i  input  DATA_W  upstream payload.
- out_valid_o  output  1  downstream payload valid.
- out_ready_i  input  1  downstream accepts the payload.
- out_data_o  output  DATA_W  downstream payload.
- stall_cnt_o  output  CNT_W  count of cycles in which downstream back-pressure blocks a valid payload.

## Operation
- Input transfer: occurs on a clock edge where in_valid_i && in_ready_o.
- Output transfer: occurs on a clock edge where out_valid_o && out_ready_i.
- Main entry (main_v, main_d) drives the outputs: out_valid_o = main_v, out_data_o = main_d.
- Invariant: main_d == BUBBLE whenever main_v == 0.
- On an output transfer with no refill, main_v clears and main_d loads BUBBLE.
- Simultaneous input and output transfer: the new payload replaces the old one. Throughput is 1 per cycle.
- Payload is never modified. It must never be duplicated or dropped, except by flush.
- Flush has the highest priority. On an edge with flush_i = 1:
  - main_v is cleared and main_d loads BUBBLE.
  - The skid entry (if built) is cleared.
  - A payload handshaken in the same cycle is discarded.
  - in_ready_o is not gated by flush_i.
- Stall counter:
  - Increments on each edge where out_valid_o && !out_ready_i.
  - Saturates at all-ones.
  - Is unaffected by flush and is cleared only by reset.
- Reset (rst low, asynchronous, any time including mid-transfer):
  - out_valid_o = 0 and out_data_o = BUBBLE.
  - Skid entry invalid.
  - stall_cnt_o = 0.
  - in_ready_o = 1.
  - No transfer occurs until the first rising edge after rst is released.

## Timing
- Latency: 1 cycle from input transfer to out_valid_o.
- Without the skid entry, in_ready_o = !main_v || out_ready_i. This is a combinational path from out_ready_i.
- With the skid entry, in_ready_o = !skid_v. This is a registered output with no combinational input-to-output path.
- out_valid_o, out_data_o and stall_cnt_o are register outputs in both configurations.

## Configuration
- PIPE_SKID_EN defined:
  - A second entry (skid_v, skid_d) is built.
  - If main_v && !out_ready_i && in_valid_i && !skid_v, the incoming payload goes to the skid entry.
  - On the next output transfer, the skid entry moves into the main entry and skid_v clears.
  - Order is preserved: main is emitted before skid.
  - Full condition: skid_v = 1 drops in_ready_o until the next output transfer.
  - Sustained throughput is still 1 per cycle.
- PIPE_SKID_EN undefined:
  - Single entry only, with the combinational in_ready_o given under Timing.
  - No skid registers are built.

## Test plan
- Reset and idle: assert rst = 0 mid-transfer with in_valid_i = 1 -> out_valid_o = 0, out_data_o = BUBBLE (top 32 bits 32'h0000_0013), stall_cnt_o = 0, in_ready_o = 1.
- Streaming: out_ready_i = 1 and a new payload 1,2,3,4 on each of four cycles -> out_data_o = 1,2,3,4 on the following four cycles, out_valid_o continuously 1, no gaps.
- Back-pressure:
  - Load payload A, then hold out_ready_i = 0 for 5 cycles while offering B -> out_data_o stays A, stall_cnt_o = 5.
  - With PIPE_SKID_EN: B sits in the skid entry and in_ready_o = 0 from cycle 2 onward.
  - Without PIPE_SKID_EN: in_ready_o = 0 throughout.
  - Release out_ready_i -> output A then B, in order.
- Flush: with A in main and B in skid, pulse flush_i while C is handshaken -> next cycle out_valid_o = 0, out_data_o = BUBBLE, and A, B and C never appear.
- Counter saturation: with CNT_W = 4, hold back-pressure for 20 cycles -> stall_cnt_o reaches 4'hF and stays there. A flush leaves it at 4'hF.
